// File: rtl/logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_pkg
//
// Shared definitions for the logic-unit arbiter slice:
//   - opcode encodings understood by the shared bitwise unit
//   - FSM state encoding of the arbiter's response register
// -----------------------------------------------------------------------------
package logic_unit_pkg;

  // Bitwise opcodes, all applied lane-wise across the full operand width.
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  // ST_IDLE: response register empty.
  // ST_RESP: response register holds a result not yet taken by the consumer.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

endpackage

// File: rtl/logic_unit.sv
// -----------------------------------------------------------------------------
// logic_unit
//
// Purely combinational WIDTH-bit bitwise unit shared by all requesters.
//
// Ports:
//   op  in  2      opcode (OP_AND / OP_OR / OP_NAND / OP_XOR)
//   a   in  WIDTH  operand A
//   b   in  WIDTH  operand B
//   y   out WIDTH  result
// -----------------------------------------------------------------------------
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter
//
// Round-robin arbiter and sequencer sharing one bitwise logic unit between
// N_REQ requesters. One request is accepted per transaction, its result is
// computed through the shared unit and captured in a registered response
// channel tagged with the requester index.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. A source holds its payload stable while valid is high and not yet
//   accepted. Requesters may drop req_valid before acceptance; the response
//   side holds rsp_y/rsp_id stable while rsp_valid is high and rsp_ready low.
//
// Ports:
//   clk        in   1            rising-edge clock
//   rst        in   1            synchronous active-high reset
//   req_valid  in   N_REQ        per-requester request valid
//   req_ready  out  N_REQ        per-requester accept, one-hot or zero
//   req_op     in   2*N_REQ      opcode of requester i at [2i+1:2i]
//   req_a      in   WIDTH*N_REQ  operand A of requester i at [WIDTH*i +: WIDTH]
//   req_b      in   WIDTH*N_REQ  operand B, same slicing
//   rsp_valid  out  1            response valid (registered)
//   rsp_ready  in   1            response consumer ready
//   rsp_id     out  ID_W         requester that owns rsp_y (registered)
//   rsp_y      out  WIDTH        result (registered)
//   dbg_state  out  1            FSM state (0 = IDLE, 1 = RESP) for observation
// -----------------------------------------------------------------------------
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int N_REQ = 2,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_y,
  output logic                   dbg_state
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [ID_W-1:0]   r_last_grant;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [WIDTH-1:0]  r_rsp_y;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic              w_can_accept;
  logic              w_found;
  logic [ID_W-1:0]   w_winner;
  logic              w_xfer;
  logic [1:0]        w_op;
  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;
  logic [WIDTH-1:0]  w_y;

  // The output register can take a new result when it is empty, or when its
  // current content is being consumed on this same edge. Reset blocks any
  // transfer so nothing is accepted in the reset cycle.
  assign w_can_accept = !rst && ((r_state == ST_IDLE) || rsp_ready);

  // Round-robin search starting just above the last grant. Done as two
  // passes over fixed indices: first the requesters numbered above
  // r_last_grant, then the wrapped ones from 0 up to r_last_grant. The first
  // valid hit wins, which is the same as scanning (last+1) mod N_REQ upward.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req_valid[i] && (ID_W'(i) > r_last_grant)) begin
        w_found  = 1'b1;
        w_winner = ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req_valid[i] && (ID_W'(i) <= r_last_grant)) begin
        w_found  = 1'b1;
        w_winner = ID_W'(i);
      end
    end
  end

  assign w_xfer = w_can_accept && w_found;

  // Ready and operand mux decode the same winner index so the grant and the
  // operands feeding the shared unit can never disagree.
  always_comb begin
    req_ready = '0;
    w_op      = '0;
    w_a       = '0;
    w_b       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        req_ready[i] = w_xfer;
        w_op         = req_op[2*i +: 2];
        w_a          = req_a[WIDTH*i +: WIDTH];
        w_b          = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shared logic unit
  // ---------------------------------------------------------------------------
  logic_unit #(
    .WIDTH (WIDTH)
  ) u_logic_unit (
    .op (w_op),
    .a  (w_a),
    .b  (w_b),
    .y  (w_y)
  );

  // ---------------------------------------------------------------------------
  // FSM, round-robin pointer and response register
  // ---------------------------------------------------------------------------
  // r_last_grant resets to the top index so requester 0 wins the first slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= ID_W'(N_REQ - 1);
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_y      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_state      <= ST_RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= w_winner;
            r_rsp_y      <= w_y;
            r_last_grant <= w_winner;
          end
        end
        ST_RESP: begin
          // Without rsp_ready nothing changes: the held response stays put.
          if (rsp_ready) begin
            if (w_xfer) begin
              // Back-to-back: old result leaves, new one lands on this edge.
              r_rsp_valid  <= 1'b1;
              r_rsp_id     <= w_winner;
              r_rsp_y      <= w_y;
              r_last_grant <= w_winner;
            end else begin
              r_state     <= ST_IDLE;
              r_rsp_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;
  assign dbg_state = (r_state == ST_RESP);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_arbiter
//
// Directed bench for logic_unit_arbiter configured with N_REQ=4, WIDTH=8,
// followed by a randomized soak checked against a bitwise reference model,
// a round-robin reference and a fairness bound. Inputs are driven and outputs
// sampled around the falling clock edge.
// -----------------------------------------------------------------------------
module tb_logic_unit_arbiter;

  localparam int WIDTH = 8;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int W     = ID_W + WIDTH;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [2*N_REQ-1:0]     req_op;
  logic [WIDTH*N_REQ-1:0] req_a;
  logic [WIDTH*N_REQ-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_y;
  logic                   dbg_state;

  always #5 clk = ~clk;

  logic_unit_arbiter #(
    .WIDTH (WIDTH),
    .N_REQ (N_REQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .dbg_state (dbg_state)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];          // {id, y} of responses not yet consumed
  int           m_last;            // model round-robin pointer
  logic [N_REQ-1:0] pending;       // valid and not yet granted
  int           wait_cnt[N_REQ];   // accept slots missed while waiting

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [ID_W-1:0] id, input logic [WIDTH-1:0] y);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".rsp_id"}, 32'(rsp_id), 32'(id));
    check({tag, ".rsp_y"}, 32'(rsp_y), 32'(y));
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".dbg_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic set_req(input int i, input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    req_op[2*i +: 2]       = op;
    req_a[WIDTH*i +: WIDTH] = a;
    req_b[WIDTH*i +: WIDTH] = b;
  endtask

  // ---------------------------------------------------------------------------
  // Reference models
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_NAND: return ~(a & b);
      default: return a ^ b;
    endcase
  endfunction

  // Returns the requester index that round-robin selects, or -1 if none valid.
  function automatic int rr_pick(input logic [N_REQ-1:0] v, input int last);
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (last + k) % N_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rot_y[4]  = '{8'h88, 8'hEE, 8'h77, 8'h66};
  logic [1:0]       sgl_op[3] = '{OP_OR, OP_NAND, OP_XOR};
  logic [WIDTH-1:0] sgl_a[3]  = '{8'h0A, 8'h0A, 8'h0C};
  logic [WIDTH-1:0] sgl_b[3]  = '{8'h05, 8'h05, 8'h0A};
  logic [WIDTH-1:0] sgl_y[4]  = '{8'h00, 8'h0F, 8'hFF, 8'h06};
  logic [ID_W-1:0]  con_id[3] = '{2'd1, 2'd0, 2'd1};
  logic [WIDTH-1:0] con_y[3]  = '{8'h30, 8'hCC, 8'h30};
  logic [N_REQ-1:0] con_rdy[3] = '{4'b0001, 4'b0010, 4'b0000};

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N_REQ; i++) set_req(i, 2'(i), 8'hCC, 8'hAA);

    // Reset held for two edges with every requester valid.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("reset.req_ready", 32'(req_ready), 32'd0);
      check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset.rsp_y", 32'(rsp_y), 32'd0);
      check("reset.rsp_id", 32'(rsp_id), 32'd0);
      check("reset.dbg_state", 32'(dbg_state), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("first_grant", 32'(req_ready), 32'b0001);

    // All four valid: grants rotate 0,1,2,3 and each applies its own opcode.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) req_valid = '0;
      #1;
      check_rsp("rotate", 2'(k), rot_y[k]);
      check("rotate.req_ready", 32'(req_ready), (k == 3) ? 32'd0 : 32'(1 << (k + 1)));
    end
    @(negedge clk);
    #1;
    check_empty("rotate.drain");

    // Single persistent requester 0 through all four opcodes.
    req_valid = 4'b0001;
    set_req(0, OP_AND, 8'h0A, 8'h05);
    #1;
    check("single.req_ready", 32'(req_ready), 32'b0001);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j < 3) set_req(0, sgl_op[j], sgl_a[j], sgl_b[j]);
      else       req_valid = '0;
      #1;
      check_rsp("single", 2'd0, sgl_y[j]);
      check("single.req_ready", 32'(req_ready), (j < 3) ? 32'b0001 : 32'd0);
    end
    @(negedge clk);
    #1;
    check_empty("single.drain");

    // Contention between 0 and 1 (last grant was 0, so 1 goes first).
    req_valid = 4'b0011;
    set_req(0, OP_XOR, 8'hF0, 8'h3C);
    set_req(1, OP_AND, 8'hF0, 8'h3C);
    #1;
    check("contend.req_ready", 32'(req_ready), 32'b0010);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) rsp_ready = 1'b0;
      #1;
      check_rsp("contend", con_id[k], con_y[k]);
      check("contend.req_ready", 32'(req_ready), 32'(con_rdy[k]));
    end

    // Backpressure: response held, no grants; release consumes and grants 0.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 4) rsp_ready = 1'b1;
      #1;
      check_rsp("backpressure", 2'd1, 8'h30);
      check("backpressure.req_ready", 32'(req_ready), (c == 4) ? 32'b0001 : 32'd0);
    end

    // Reset while a response is held and not consumed.
    @(negedge clk);
    rst       = 1'b1;
    rsp_ready = 1'b0;
    #1;
    check_rsp("pre_reset", 2'd0, 8'hCC);
    check("mid_reset.req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check_empty("mid_reset");
    check("mid_reset.rsp_id", 32'(rsp_id), 32'd0);
    check("mid_reset.rsp_y", 32'(rsp_y), 32'd0);
    check("mid_reset.req_ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    check_rsp("post_reset", 2'd0, 8'hCC);
    check("post_reset.req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    check_empty("post_reset.drain");

    // Randomized soak against the reference models.
    m_last  = 0;
    pending = '0;
    for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int  pick;
      logic can_acc;
      check("soak.rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("soak.rsp_id", 32'(rsp_id), 32'(exp_q[0][W-1:WIDTH]));
        check("soak.rsp_y", 32'(rsp_y), 32'(exp_q[0][WIDTH-1:0]));
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!pending[i]) begin
          req_valid[i] = (cyc < 390) && ($urandom_range(0, 99) < 60);
          set_req(i, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)));
        end
      end
      rsp_ready = (cyc >= 390) || ($urandom_range(0, 3) != 0);
      #1;
      can_acc = (exp_q.size() == 0) || rsp_ready;
      pick    = rr_pick(req_valid, m_last);
      check("soak.req_ready", 32'(req_ready),
            (can_acc && pick >= 0) ? 32'(1 << pick) : 32'd0);
      if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
      if (can_acc && pick >= 0) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (req_valid[i]) begin
            if (i == pick) begin
              check("soak.fairness", 32'(wait_cnt[i] <= N_REQ - 1), 32'd1);
              wait_cnt[i] = 0;
            end else begin
              wait_cnt[i]++;
            end
          end
        end
        exp_q.push_back({2'(pick), ref_op(req_op[2*pick +: 2], req_a[WIDTH*pick +: WIDTH],
                                          req_b[WIDTH*pick +: WIDTH])});
        m_last = pick;
      end
      for (int i = 0; i < N_REQ; i++) begin
        pending[i] = req_valid[i] && !(can_acc && pick == i);
      end
      @(negedge clk);
    end
    #1;
    check("soak.drained", 32'(exp_q.size()), 32'd0);
    check_empty("soak.end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit logic unit (AND/OR/NAND/XOR) between N_REQ requesters. Each requester presents an opcode and two operands with a valid/ready handshake. The block grants one requester per transaction, computes the result through the shared unit, and returns it on a registered response channel tagged with the requester index. It sits between the gate-level datapath and any client blocks that need bitwise operations without owning a dedicated gate instance.

## Interface
- WIDTH, 4, operand/result width in bits (≥1)
- N_REQ, 2, number of requesters (2..8)
- ID_W, $clog2(N_REQ), width of requester index (derived, not overridable)

- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, synchronous, active-high
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester grant/accept; at most one bit high (one-hot or zero)
- req_op  in  2*N_REQ  opcode per requester, requester i at bits [2i+1:2i]
- req_a  in  WIDTH*N_REQ  operand A per requester, slice i at [WIDTH*i +: WIDTH]
- req_b  in  WIDTH*N_REQ  operand B per requester, same slicing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  index of requester that owns rsp_y
- rsp_y  out  WIDTH  result

## Operation
- Opcodes: 2'b00 AND, 2'b01 OR, 2'b10 NAND, 2'b11 XOR; all bitwise over WIDTH bits, no carry, no sign.
- FSM states: IDLE (no response held), RESP (response held in output register).
- Accept condition `can_accept` = (state==IDLE) || (state==RESP && rsp_ready).
- Arbitration: when can_accept and any req_valid, the winner is the first asserted req_valid searching from (last_grant+1) mod N_REQ upward with wrap. req_ready[winner]=1 combinationally in that cycle; all other bits 0. When !can_accept, req_ready is all-zero.
- Transfer on requester i happens when req_valid[i] && req_ready[i]. On transfer: rsp_y <= op(a_i, b_i), rsp_id <= i, last_grant <= i, state <= RESP.
- IDLE: transfer → RESP; else stay.
- RESP: rsp_ready && transfer → stay RESP with new data (back-to-back); rsp_ready && no valid request → IDLE; !rsp_ready → hold rsp_y/rsp_id stable, stay.
- Requesters must hold req_op/a/b stable while req_valid is high and unaccepted; the block does not check for this. Dropping req_valid before acceptance is permitted, and that requester is simply not granted.
- Reset values: state=IDLE, last_grant=N_REQ-1 (so requester 0 wins first), rsp_valid=0, rsp_id=0, rsp_y=0, req_ready=0.
- Reset mid-RESP discards the held response; no transfer occurs in the reset cycle (req_ready forced 0 while rst=1).

## Timing
- Request-to-response latency: 1 cycle; rsp_valid rises on the edge that completes the transfer.
- Throughput: one transaction per cycle while rsp_ready stays high.
- rsp_valid, rsp_y, rsp_id are registered outputs. req_ready is combinational from req_valid, state, rsp_ready and last_grant. No combinational path from req_op/a/b to any output.
- Simultaneous events: all requesters valid every cycle → grants rotate 0,1,…,N_REQ-1,0,… with no repeats. A single persistent requester is granted every accept slot.
- Fairness bound: a continuously valid requester is granted within N_REQ accept slots.

## Structure
- Shared package `logic_unit_pkg`: opcode localparams (OP_AND, OP_OR, OP_NAND, OP_XOR), FSM state encoding (ST_IDLE, ST_RESP).
- Sub-module `logic_unit`: purely combinational, WIDTH parameter; inputs op, a, b; output y. One instance, fed by the winner's muxed operands.
- Top level holds the round-robin pointer, the FSM and the response register.

## Test plan
- Reset: assert rst 2 cycles with all req_valid=1 → req_ready=0, rsp_valid=0, rsp_y=0 throughout; first grant after release goes to requester 0.
- Single requester: req0 op=AND, a=4'b1010, b=4'b0101 → req_ready[0] same cycle; next cycle rsp_valid=1, rsp_y=4'b0000, rsp_id=0. Repeat with OR → 4'b1111, NAND → 4'b1111, XOR with a=4'b1100, b=4'b1010 → 4'b0110.
- Contention: req0 and req1 both valid with rsp_ready=1 → grants alternate 0,1,0,1; rsp_id follows one cycle later; req_ready is never two-hot.
- Backpressure: rsp_ready=0 for 5 cycles after a response → rsp_y/rsp_id held, req_ready=0; raising rsp_ready → held response consumed and pending request granted in the same cycle.
- Reset mid-operation: rst in RESP with rsp_ready=0 → next cycle rsp_valid=0, last_grant restored; pending req1 waits and req0 wins if both valid.
- Randomized soak (N_REQ=4, WIDTH=8): scoreboard checks every result against the bitwise reference model and per-requester ordering, and checks the fairness bound of 4 accept slots.
